// File: rtl/audio_pkg.sv
// Shared widths, sample/bus types and the gain/truncation arithmetic for the audio conditioner.
package audio_pkg;

   localparam int unsigned WIDTH_IN     = 24;
   localparam int unsigned WIDTH_OUT    = 16;
   localparam int unsigned NUM_CHANNELS = 2;
   localparam int unsigned FIFO_DEPTH   = 8;
   localparam int unsigned GAIN_BITS    = 4;
   localparam int unsigned DC_SHIFT     = 10;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned CH_W     = ch_width(NUM_CHANNELS);
   localparam int unsigned CH_SLOTS = 1 << CH_W;
   localparam int unsigned EXT_W    = WIDTH_IN + (1 << GAIN_BITS) - 1;

   typedef logic signed [WIDTH_IN-1:0]  sample_in_t;
   typedef logic signed [WIDTH_OUT-1:0] sample_out_t;
   typedef logic [CH_W-1:0]             chan_t;
   typedef logic [GAIN_BITS-1:0]        gain_t;

   typedef struct packed {
      chan_t       channel;
      sample_out_t sample;
   } out_word_t;

   localparam sample_in_t SAT_MAX = {1'b0, {(WIDTH_IN-1){1'b1}}};
   localparam sample_in_t SAT_MIN = {1'b1, {(WIDTH_IN-1){1'b0}}};

   // Left shift in a wide enough domain, then clamp back into WIDTH_IN signed range.
   function automatic sample_in_t sat_shift(input sample_in_t x, input gain_t g);
      logic signed [EXT_W-1:0] y;
      sample_in_t              r;
      y = EXT_W'(x) <<< g;
      if ((y[EXT_W-1:WIDTH_IN-1] == '0) || (y[EXT_W-1:WIDTH_IN-1] == '1))
         r = y[WIDTH_IN-1:0];
      else
         r = y[EXT_W-1] ? SAT_MIN : SAT_MAX;
      return r;
   endfunction

   function automatic sample_out_t truncate(input sample_in_t x);
      return x[WIDTH_IN-1 -: WIDTH_OUT];
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO with registered head, valid flag and occupancy count.
module sample_fifo #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     ready,
   output logic                     valid,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             pop;

   // Next head bypasses the write when the incoming word lands on the new read slot.
   always_comb begin
      pop        = valid & ready;
      rd_ptr_nxt = rd_ptr + AW'(pop);
      count_nxt  = count + CW'(push) - CW'(pop);
      head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         dout   <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         valid  <= (count_nxt != '0);
         dout   <= head_nxt;
      end
   end

endmodule

// File: rtl/audio_conditioner.sv
// Per-channel shift gain, saturation and truncation into an output FIFO; input overflow is counted.
// Optional per-channel DC blocker stage enabled by defining AUDIO_COND_DC_BLOCK_EN.
module audio_conditioner
   import audio_pkg::*;
(
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [WIDTH_IN-1:0]               sample_in,
   input  logic [CH_W-1:0]                   channel_in,
   input  logic                              valid_in,
   output logic                              ready_out,
   input  logic [NUM_CHANNELS*GAIN_BITS-1:0] gain_in,
   input  logic [NUM_CHANNELS-1:0]           chan_mask_in,
   output logic [WIDTH_OUT-1:0]              sample_out,
   output logic [CH_W-1:0]                   channel_out,
   output logic                              valid_out,
   input  logic                              ready_in,
   output logic                              overflow_out,
   output logic [15:0]                       drop_count
);

   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OUT_W      = $bits(out_word_t);
   localparam int unsigned GAIN_EXT_W = CH_SLOTS * GAIN_BITS;

   logic [CH_SLOTS-1:0]   mask_ext;
   logic [GAIN_EXT_W-1:0] gain_ext;
   logic                  accept;
   logic                  push;
   logic                  pop;
   out_word_t             push_word;
   out_word_t             head_word;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W-1:0]      count_nxt;
   int unsigned           occupancy_nxt;

   logic       s1_valid;
   logic       s1_keep;
   sample_in_t s1_sample;
   chan_t      s1_chan;
   gain_t      s1_gain;

   logic       g_valid;
   logic       g_keep;
   sample_in_t g_sample;
   chan_t      g_chan;
   gain_t      g_gain;

   // Out-of-range channel tags index zero-padded mask bits, so they read as masked.
   always_comb begin
      mask_ext          = CH_SLOTS'(chan_mask_in);
      gain_ext          = GAIN_EXT_W'(gain_in);
      accept            = valid_in & ready_out;
      push              = g_valid & g_keep;
      push_word.channel = g_chan;
      push_word.sample  = truncate(sat_shift(g_sample, g_gain));
      pop               = valid_out & ready_in;
      count_nxt         = fifo_count + CNT_W'(push) - CNT_W'(pop);
`ifdef AUDIO_COND_DC_BLOCK_EN
      occupancy_nxt     = 32'(count_nxt) + 32'(accept) + 32'(s1_valid);
`else
      occupancy_nxt     = 32'(count_nxt) + 32'(accept);
`endif
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         s1_valid  <= 1'b0;
         s1_keep   <= 1'b0;
         s1_sample <= '0;
         s1_chan   <= '0;
         s1_gain   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_keep   <= mask_ext[channel_in];
            s1_sample <= sample_in;
            s1_chan   <= channel_in;
            s1_gain   <= gain_ext[int'(channel_in)*GAIN_BITS +: GAIN_BITS];
         end
      end
   end

   // Space is reserved for everything already in flight, so a push never meets a full FIFO.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ready_out    <= 1'b0;
         overflow_out <= 1'b0;
         drop_count   <= '0;
      end else begin
         ready_out <= (occupancy_nxt < FIFO_DEPTH);
         if (valid_in && !ready_out) begin
            overflow_out <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end

`ifdef AUDIO_COND_DC_BLOCK_EN
   localparam int unsigned ACC_W = WIDTH_IN + DC_SHIFT;

   logic signed [ACC_W-1:0]    acc [CH_SLOTS];
   logic signed [ACC_W-1:0]    acc_cur;
   sample_in_t                 dc_est;
   logic signed [WIDTH_IN:0]   dc_diff;
   sample_in_t                 dc_out;
   logic                       d_valid;
   logic                       d_keep;
   sample_in_t                 d_sample;
   chan_t                      d_chan;
   gain_t                      d_gain;

   // One-pole DC estimate per channel; the accumulator tracks the unsaturated difference.
   always_comb begin
      acc_cur = acc[s1_chan];
      dc_est  = WIDTH_IN'(acc_cur >>> DC_SHIFT);
      dc_diff = (WIDTH_IN+1)'(s1_sample) - (WIDTH_IN+1)'(dc_est);
      if (dc_diff[WIDTH_IN] != dc_diff[WIDTH_IN-1])
         dc_out = dc_diff[WIDTH_IN] ? SAT_MIN : SAT_MAX;
      else
         dc_out = dc_diff[WIDTH_IN-1:0];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < int'(CH_SLOTS); i++) acc[i] <= '0;
         d_valid  <= 1'b0;
         d_keep   <= 1'b0;
         d_sample <= '0;
         d_chan   <= '0;
         d_gain   <= '0;
      end else begin
         d_valid <= s1_valid;
         if (s1_valid) begin
            d_keep   <= s1_keep;
            d_sample <= dc_out;
            d_chan   <= s1_chan;
            d_gain   <= s1_gain;
         end
         if (s1_valid && s1_keep) acc[s1_chan] <= acc_cur + ACC_W'(dc_diff);
      end
   end

   assign g_valid  = d_valid;
   assign g_keep   = d_keep;
   assign g_sample = d_sample;
   assign g_chan   = d_chan;
   assign g_gain   = d_gain;
`else
   assign g_valid  = s1_valid;
   assign g_keep   = s1_keep;
   assign g_sample = s1_sample;
   assign g_chan   = s1_chan;
   assign g_gain   = s1_gain;
`endif

   sample_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .push  (push),
      .din   (push_word),
      .ready (ready_in),
      .valid (valid_out),
      .dout  (head_word),
      .count (fifo_count)
   );

   assign sample_out  = head_word.sample;
   assign channel_out = head_word.channel;

endmodule

// File: tb/tb_audio_conditioner.sv
// Randomised and directed bench for audio_conditioner against an occupancy/queue reference model.
module tb_audio_conditioner;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [23:0] sample_in;
   logic [0:0]  channel_in;
   logic        valid_in;
   logic        ready_out;
   logic [7:0]  gain_in;
   logic [1:0]  chan_mask_in;
   logic [15:0] sample_out;
   logic [0:0]  channel_out;
   logic        valid_out;
   logic        ready_in;
   logic        overflow_out;
   logic [15:0] drop_count;

   always #5 clk_in = ~clk_in;

   audio_conditioner dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .sample_in    (sample_in),
      .channel_in   (channel_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .gain_in      (gain_in),
      .chan_mask_in (chan_mask_in),
      .sample_out   (sample_out),
      .channel_out  (channel_out),
      .valid_out    (valid_out),
      .ready_in     (ready_in),
      .overflow_out (overflow_out),
      .drop_count   (drop_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: multiply by 2^g, clamp to 24-bit signed, floor-divide by 256.
   function automatic logic [15:0] expect_sample(input logic [23:0] x, input int g);
      longint y;
      y = longint'($signed(x)) * (longint'(1) << g);
      if (y > 64'sd8388607)  y = 64'sd8388607;
      if (y < -64'sd8388608) y = -64'sd8388608;
      return 16'(y >>> 8);
   endfunction

   typedef struct {
      logic [15:0] s;
      int          ch;
   } item_t;

   item_t fifo_q[$];
   item_t st_item;
   bit    st_v    = 1'b0;
   bit    st_keep = 1'b0;
   bit    m_ready = 1'b0;
   int    m_drops = 0;
   int    m_pops  = 0;

   // Model: FIFO contents plus one accepted-but-not-yet-pushed stage; space counts both.
   initial forever begin
      @(posedge clk_in or negedge rst_in);
      if (!rst_in) begin
         fifo_q.delete();
         st_v    = 1'b0;
         st_keep = 1'b0;
         m_ready = 1'b0;
         m_drops = 0;
      end else begin
         if (fifo_q.size() != 0 && ready_in) begin
            void'(fifo_q.pop_front());
            m_pops++;
         end
         if (st_v && st_keep) fifo_q.push_back(st_item);
         st_v = 1'b0;
         if (valid_in) begin
            if (m_ready) begin
               st_v       = 1'b1;
               st_keep    = chan_mask_in[channel_in];
               st_item.ch = int'(channel_in);
               st_item.s  = expect_sample(sample_in, int'(gain_in[int'(channel_in)*4 +: 4]));
            end else if (m_drops < 65535) begin
               m_drops++;
            end
         end
         m_ready = (fifo_q.size() + int'(st_v)) < 8;
      end
   end

   // Per-cycle comparison of every output against the model.
   initial forever begin
      @(negedge clk_in);
      check("valid_out", longint'(valid_out), longint'(fifo_q.size() != 0));
      check("ready_out", longint'(ready_out), longint'(m_ready));
      check("drop_count", longint'(drop_count), longint'(m_drops));
      check("overflow_out", longint'(overflow_out), longint'(m_drops != 0));
      if (fifo_q.size() != 0) begin
         check("sample_out", longint'(sample_out), longint'(fifo_q[0].s));
         check("channel_out", longint'(channel_out), longint'(fifo_q[0].ch));
      end
   end

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) @(negedge clk_in);
   endtask

   task automatic send(input logic [23:0] x, input logic ch);
      sample_in  = x;
      channel_in = ch;
      valid_in   = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
   endtask

   int          pops0;
   logic [23:0] r;

   initial begin
      sample_in    = '0;
      channel_in   = '0;
      valid_in     = 1'b0;
      gain_in      = '0;
      chan_mask_in = 2'b11;
      ready_in     = 1'b1;
      #1 rst_in = 1'b0;
      #1;
      check("rst_valid_out", longint'(valid_out), 0);
      check("rst_sample_out", longint'(sample_out), 0);
      check("rst_ready_out", longint'(ready_out), 0);
      check("rst_drop_count", longint'(drop_count), 0);
      check("rst_overflow", longint'(overflow_out), 0);
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      check("ready_after_release", longint'(ready_out), 1);

      // Unity gain, two-cycle latency
      send(24'h123456, 1'b0);
      check("t1_not_yet", longint'(valid_out), 0);
      @(negedge clk_in);
      check("t1_valid", longint'(valid_out), 1);
      check("t1_sample", longint'(sample_out), 16'h1234);
      check("t1_channel", longint'(channel_out), 0);
      idle(2);

      // Positive clamp and exact negative full scale
      gain_in = 8'h04;
      send(24'h080000, 1'b0);
      send(24'hF80000, 1'b0);
      check("t2_clamp", longint'(sample_out), 16'h7FFF);
      @(negedge clk_in);
      check("t2_exact_min", longint'(sample_out), 16'h8000);
      gain_in = 8'h00;
      idle(3);

      // Fill under back-pressure, ninth strobe dropped, then ordered drain
      ready_in = 1'b0;
      valid_in = 1'b1;
      for (int i = 0; i < 9; i++) begin
         sample_in  = 24'((i + 1) << 12);
         channel_in = 1'(i);
         @(negedge clk_in);
      end
      valid_in = 1'b0;
      check("t3_ready_low", longint'(ready_out), 0);
      check("t3_drop_count", longint'(drop_count), 1);
      check("t3_overflow", longint'(overflow_out), 1);
      check("t3_head_first", longint'(sample_out), 16'h0010);
      pops0    = m_pops;
      ready_in = 1'b1;
      idle(12);
      check("t3_drained", longint'(m_pops - pops0), 8);
      check("t3_empty", longint'(valid_out), 0);

      // Channel 1 masked off
      chan_mask_in = 2'b01;
      pops0        = m_pops;
      for (int i = 0; i < 6; i++) send(24'($urandom), 1'(i));
      idle(5);
      check("t4_only_ch0", longint'(m_pops - pops0), 3);
      check("t4_no_new_drops", longint'(drop_count), 1);
      chan_mask_in = 2'b11;

      // Long constant stream
      sample_in  = 24'h100000;
      channel_in = 1'b0;
      valid_in   = 1'b1;
      repeat (8192) @(negedge clk_in);
      idle(4);
      check("t5_const", longint'(sample_out), 16'h1000);
      check("t5_no_drops", longint'(drop_count), 1);

      // Random traffic
      repeat (3000) begin
         r          = 24'($urandom);
         sample_in  = 24'($signed(r) >>> $urandom_range(0, 23));
         channel_in = 1'($urandom);
         valid_in   = ($urandom_range(0, 9) < 6);
         ready_in   = 1'($urandom);
         gain_in    = 8'($urandom);
         if ($urandom_range(0, 31) == 0) chan_mask_in = 2'($urandom);
         @(negedge clk_in);
      end
      ready_in = 1'b1;
      idle(20);
      check("rand_drained", longint'(valid_out), 0);

      // Asynchronous reset with data held in the FIFO
      chan_mask_in = 2'b11;
      gain_in      = 8'h00;
      ready_in     = 1'b0;
      send(24'h111111, 1'b0);
      send(24'h222222, 1'b1);
      send(24'h333333, 1'b0);
      idle(3);
      check("t6_held", longint'(valid_out), 1);
      @(posedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      check("t6_valid_cleared", longint'(valid_out), 0);
      check("t6_sample_cleared", longint'(sample_out), 0);
      check("t6_drops_cleared", longint'(drop_count), 0);
      check("t6_overflow_cleared", longint'(overflow_out), 0);
      @(negedge clk_in);
      rst_in   = 1'b1;
      ready_in = 1'b1;
      @(negedge clk_in);
      send(24'h0ABCDE, 1'b1);
      @(negedge clk_in);
      check("t6_new_sample", longint'(sample_out), 16'h0ABC);
      check("t6_new_channel", longint'(channel_out), 1);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
